alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one ALU instance between two requesters, for example the execute stage and a multi-cycle helper unit. Round-robin arbitration admits one operation at a time. The block holds the operands and control code steady on the ALU port for a full execute cycle, then registers the result and the n,z,c,v flags. Each requester receives its response over a valid/ready handshake on a shared response bus.

Parameters:
WIDTH, 32, operand/result width; must match the attached ALU's width.
NUM_OPS, 9, number of legal ALU control codes (0..NUM_OPS-1); codes at or above this are illegal.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  2  bit i: requester i presents an operation.
req_ready  out  2  bit i: operation from requester i accepted this cycle.
req0_a, req0_b  in  WIDTH  requester 0 operands.
req0_ctrl  in  4  requester 0 ALU control code.
req1_a, req1_b  in  WIDTH  requester 1 operands.
req1_ctrl  in  4  requester 1 ALU control code.
rsp_valid  out  2  bit i: response bus holds requester i's result; one-hot or zero.
rsp_ready  in  2  bit i: requester i consumes the response.
rsp_result  out  WIDTH  registered ALU result.
rsp_flags  out  4  registered flags {n,z,c,v}.
rsp_err  out  1  operation used an illegal control code.
alu_a, alu_b  out  WIDTH  driven to the ALU.
alu_control  out  4  driven to the ALU.
alu_result  in  WIDTH  ALU result.
alu_flags  in  4  ALU flags {n,z,c,v}.
busy  out  1  high in EXEC and RESP.

Behaviour:
- Reset state (rst=1 at an edge):
  - state=IDLE, all outputs 0, priority pointer favours requester 0.
  - Any in-flight operation is discarded with no response.
  - Reset dominates all other inputs.
- ALU encoding: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 xor, 7 mul, 8 nop.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted last. After reset, the first tie goes to requester 0.
  - The grant asserts req_ready[g] combinationally in the same cycle. The grant depends only on req_valid and the pointer.
  - Capture operands, ctrl, owner id g and illegal = (ctrl >= NUM_OPS). Update the pointer. Go to EXEC.
  - No requester valid: stay in IDLE; req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_a, alu_b and alu_control come from the captured registers.
  - If illegal: alu_control=8 (nop).
  - At the end of the cycle, register rsp_result and rsp_flags from the ALU. If illegal, register result=0, flags=0 and rsp_err=1 instead.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; result, flags and err held stable.
  - Leave only when rsp_ready[owner]=1, then go to IDLE and clear rsp_valid.
  - rsp_ready on the non-owner bit is ignored.
- Outside EXEC, alu_a, alu_b and alu_control hold the captured values, so the ALU inputs do not toggle.
- req_ready is 0 outside IDLE. Requesters hold valid and operands stable until ready; the block never drops a held request.
- Latency: accept at edge N, rsp_valid high from cycle N+1 through N+2 onward. Minimum 3 cycles per operation, because IDLE is re-entered before the next accept.
- A requester whose request is pending may also be waiting on its own response. The two are independent, and the response is always delivered first.
- Starvation bound: a continuously valid requester is granted within 2 grants.

Test Plan:
- Reset mid-EXEC (req0 add 5+7 accepted, rst next cycle) -> rsp_valid stays 0; state IDLE; next req1 accepted normally.
- Single op: req0 add a=5, b=7 -> req_ready[0] in the accept cycle; two cycles later rsp_valid=2'b01, rsp_result=12, rsp_flags=0000, rsp_err=0.
- Sub with zero: req1 sub a=9, b=9 -> rsp_valid=2'b10, result=0, z=1, err=0.
- Contention: both valid continuously, req0 add 1+1, req1 xor F0^0F -> grants alternate 0,1,0,1; each response carries the correct owner and result (2, then 0xFF).
- Illegal ctrl: req0 ctrl=4'hC -> alu_control=8 during EXEC; rsp_result=0, flags=0, rsp_err=1.
- Backpressure: rsp_ready[0]=0 for 5 cycles while req1 is valid -> response stays stable, req_ready[1]=0; req1 is accepted one cycle after rsp_ready[0] rises.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one external ALU.
// Each operation runs IDLE -> EXEC -> RESP; the response is held until its owner takes it.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [4:0] NUM_OPS_L = 5'(NUM_OPS);
    localparam logic [3:0] CTRL_NOP  = 4'd8;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [3:0]        ctrl_reg;
    logic              illegal_reg;
    logic              owner_reg;
    logic              last_reg;
    logic [1:0]        rsp_valid_reg;
    logic [WIDTH-1:0]  rsp_result_reg;
    logic [3:0]        rsp_flags_reg;
    logic              rsp_err_reg;

    logic [1:0]        grant;
    logic              gid;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [3:0]        sel_ctrl;
    logic              sel_illegal;

    // Grant depends only on req_valid and the pointer; a tie goes to whoever was not served last.
    always_comb begin
        grant = 2'b00;
        gid   = 1'b0;
        if (state_reg == IDLE) begin
            unique case (req_valid)
                2'b01:   begin gid = 1'b0;      grant = 2'b01; end
                2'b10:   begin gid = 1'b1;      grant = 2'b10; end
                2'b11:   begin gid = ~last_reg; grant = last_reg ? 2'b01 : 2'b10; end
                default: begin gid = 1'b0;      grant = 2'b00; end
            endcase
        end
    end

    assign sel_a       = gid ? req1_a    : req0_a;
    assign sel_b       = gid ? req1_b    : req0_b;
    assign sel_ctrl    = gid ? req1_ctrl : req0_ctrl;
    assign sel_illegal = ({1'b0, sel_ctrl} >= NUM_OPS_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            ctrl_reg       <= '0;
            illegal_reg    <= 1'b0;
            owner_reg      <= 1'b0;
            last_reg       <= 1'b1;
            rsp_valid_reg  <= 2'b00;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (grant != 2'b00) begin
                        a_reg       <= sel_a;
                        b_reg       <= sel_b;
                        // Illegal codes are turned into a nop so the ALU never sees them.
                        ctrl_reg    <= sel_illegal ? CTRL_NOP : sel_ctrl;
                        illegal_reg <= sel_illegal;
                        owner_reg   <= gid;
                        last_reg    <= gid;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_reg <= illegal_reg ? '0 : alu_result;
                    rsp_flags_reg  <= illegal_reg ? 4'b0000 : alu_flags;
                    rsp_err_reg    <= illegal_reg;
                    rsp_valid_reg  <= owner_reg ? 2'b10 : 2'b01;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= 2'b00;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready   = grant;
    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign alu_control = ctrl_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_flags   = rsp_flags_reg;
    assign rsp_err     = rsp_err_reg;
    assign busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached.
// Accepted requests push expected responses; delivered responses are popped and compared.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control, alu_flags;
    logic        busy;

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .NUM_OPS(9)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy)
    );

    // Returns {n,z,c,v, result}; c is carry for add and borrow for sub.
    function automatic logic [35:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        cy, ov;
        t = '0; r = '0; cy = 1'b0; ov = 1'b0;
        case (c)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; cy = t[32];
                        ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; cy = (a < b); ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a << b[4:0];
            4'd5: r = a >> b[4:0];
            4'd6: r = a ^ b;
            4'd7: r = a * b;
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), cy, ov, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_control, alu_a, alu_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request side: every handshake pushes its expected response.
    always @(negedge clk) begin : req_mon
        exp_t        e;
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [35:0] m;
        if (!rst && req_ready != 2'b00) begin
            check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    c = (i == 0) ? req0_ctrl : req1_ctrl;
                    a = (i == 0) ? req0_a : req1_a;
                    b = (i == 0) ? req0_b : req1_b;
                    m = alu_model(c, a, b);
                    e.owner = i[0];
                    if (c >= 4'd9) begin
                        e.res = '0; e.fl = '0; e.err = 1'b1;
                    end else begin
                        e.res = m[31:0]; e.fl = m[35:32]; e.err = 1'b0;
                    end
                    sb.push_back(e);
                    $display("accept req%0d ctrl=%0d a=%0h b=%0h", i, c, a, b);
                end
            end
        end
    end

    // Response side: a consumed response must match the oldest expectation.
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        if (!rst && rsp_valid != 2'b00 && (rsp_valid & rsp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 64'(rsp_valid), e.owner ? 64'd2 : 64'd1);
                check("rsp_result", 64'(rsp_result), 64'(e.res));
                check("rsp_flags", 64'(rsp_flags), 64'(e.fl));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                $display("response owner=%0d result=%0h flags=%b err=%0d", e.owner, rsp_result, rsp_flags, rsp_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns #1 after the accepting edge (the EXEC cycle).
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        int k;
        if (i == 0) begin req0_a = a; req0_b = b; req0_ctrl = c; end
        else        begin req1_a = a; req1_b = b; req1_ctrl = c; end
        req_valid[i] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req_ready[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[i]) check("accept_timeout", 64'd0, 64'd1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int got[$];
        int k;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_alu_ctrl", 64'(alu_control), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);

        // Reset while EXEC discards the operation.
        issue(0, 32'd5, 32'd7, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            check("rst_exec_valid", 64'(rsp_valid), 64'd0);
            check("rst_exec_busy", 64'(busy), 64'd0);
            tick();
        end
        issue(1, 32'h10, 32'h01, 4'd3);
        wait_idle();

        // Single op with cycle-exact latency.
        issue(0, 32'd5, 32'd7, 4'd0);
        check("exec_alu_a", 64'(alu_a), 64'd5);
        check("exec_alu_b", 64'(alu_b), 64'd7);
        check("exec_alu_ctrl", 64'(alu_control), 64'd0);
        check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("exec_busy", 64'(busy), 64'd1);
        tick();
        check("add_valid", 64'(rsp_valid), 64'd1);
        check("add_result", 64'(rsp_result), 64'd12);
        check("add_flags", 64'(rsp_flags), 64'd0);
        wait_idle();

        issue(1, 32'd9, 32'd9, 4'd1);
        tick();
        check("sub_valid", 64'(rsp_valid), 64'd2);
        check("sub_z", 64'(rsp_flags[2]), 64'd1);
        check("sub_result", 64'(rsp_result), 64'd0);
        wait_idle();

        issue(0, 32'd3, 32'd4, 4'hC);
        check("illegal_alu_ctrl", 64'(alu_control), 64'd8);
        tick();
        check("illegal_err", 64'(rsp_err), 64'd1);
        check("illegal_result", 64'(rsp_result), 64'd0);
        wait_idle();

        // Contention after reset: ties alternate starting with requester 0.
        rst = 1'b1; tick(); rst = 1'b0;
        req0_a = 32'd1;    req0_b = 32'd1;    req0_ctrl = 4'd0;
        req1_a = 32'hF0;   req1_b = 32'h0F;   req1_ctrl = 4'd6;
        req_valid = 2'b11;
        k = 0;
        while (got.size() < 4 && k < 80) begin
            @(negedge clk);
            if (req_ready[0]) got.push_back(0);
            else if (req_ready[1]) got.push_back(1);
            k++;
        end
        tick();
        req_valid = 2'b00;
        check("rr_grant_count", 64'(got.size()), 64'd4);
        foreach (got[i]) check("rr_grant", 64'(got[i]), 64'(i % 2));
        wait_idle();

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready = 2'b10;
        issue(0, 32'd3, 32'd4, 4'd0);
        req1_a = 32'h0FF0; req1_b = 32'h00FF; req1_ctrl = 4'd2;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_result", 64'(rsp_result), 64'd7);
            check("bp_ready1", 64'(req_ready[1]), 64'd0);
        end
        rsp_ready = 2'b11;
        tick();
        check("bp_accept1", 64'(req_ready), 64'd2);
        tick();
        req_valid[1] = 1'b0;
        wait_idle();

        for (int n = 0; n < 8; n++) begin
            issue(int'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 10)));
            wait_idle();
        end

        wait_idle();
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
